// File: rtl/serial_adder_pkg.sv
// Shared FSM state type and elaboration-time helpers for serial_adder_pipe.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned calc_ndig(input int unsigned width, input int unsigned digit);
    return (digit == 0) ? 0 : width / digit;
  endfunction

  function automatic bit width_ok(input int unsigned width, input int unsigned digit);
    return (digit >= 1) && (width >= digit) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/serial_adder_digit.sv
// Combinational DIGIT-bit ripple adder; also exposes the carry into its top bit
// so the parent can form two's-complement overflow.
module serial_adder_digit #(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [DIGIT:0] w_c;

  always_comb begin
    w_c    = '0;
    s      = '0;
    w_c[0] = ci;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      s[i]     = x[i] ^ y[i] ^ w_c[i];
      w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
    end
  end

  assign co    = w_c[DIGIT];
  assign c_msb = w_c[DIGIT-1];

endmodule

// File: rtl/serial_adder_pipe.sv
// Digit-serial adder with valid/ready handshakes: DIGIT bits per clock, LSB first.
// Define SERIAL_ADDER_SUB_EN to add the 'sub' port (a - b - cin, cout = borrow).
module serial_adder_pipe
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NDIG     = calc_ndig(WIDTH, DIGIT);
  localparam bit          WIDTH_OK = width_ok(WIDTH, DIGIT);
  localparam int unsigned CW       = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] K_LAST = CW'(NDIG - 1);

  if (!WIDTH_OK) begin : g_bad_cfg
    $error("serial_adder_pipe: WIDTH must be a nonzero multiple of DIGIT");
  end

  state_t r_state, w_next;

  logic [WIDTH-1:0] r_a, r_b, r_sum;
  logic [CW-1:0]    r_k;
  logic             r_carry, r_cout, r_ovf;

  logic             w_accept, w_step, w_last;
  logic             w_sub_in, w_sub;
  int unsigned      w_shamt;
  logic [DIGIT-1:0] w_x, w_y, w_s;
  logic             w_co, w_cmsb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = RUN;
      end
      RUN: begin
        if (r_k == K_LAST) w_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_step   = (r_state == RUN);
  assign w_last   = w_step && (r_k == K_LAST);

`ifdef SERIAL_ADDER_SUB_EN
  logic r_sub;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_sub <= 1'b0;
    else if (w_accept) r_sub <= sub;
  end
  assign w_sub_in = sub;
  assign w_sub    = r_sub;
`else
  assign w_sub_in = 1'b0;
  assign w_sub    = 1'b0;
`endif

  // Digit k is selected by shifting rather than a variable part-select.
  assign w_shamt = 32'(r_k) * DIGIT;
  assign w_x     = DIGIT'(r_a >> w_shamt);
  assign w_y     = DIGIT'(r_b >> w_shamt) ^ {DIGIT{w_sub}};

  serial_adder_digit #(.DIGIT(DIGIT)) u_digit (
    .x     (w_x),
    .y     (w_y),
    .ci    (r_carry),
    .s     (w_s),
    .co    (w_co),
    .c_msb (w_cmsb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_k     <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_k     <= '0;
      r_carry <= cin ^ w_sub_in;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_step) begin
      // sum is cleared on accept, so OR-ing the shifted digit fills slice k.
      r_sum   <= r_sum | (WIDTH'(w_s) << w_shamt);
      r_carry <= w_co;
      r_k     <= w_last ? '0 : r_k + CW'(1);
      if (w_last) begin
        r_cout <= w_co ^ w_sub;
        r_ovf  <= w_cmsb ^ w_co;
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: doc/serial_adder_pipe.md
Name: serial_adder_pipe

Overview:
- Parametrised multi-cycle adder that succeeds the single-bit full adder cell.
- Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, LSB digit first.
- Uses valid/ready handshakes on both input and output.
- Sits between operand registers and the result bus where area matters more than latency.

Parameters:
- WIDTH, 8: operand and sum width. Must be an integer multiple of DIGIT.
- DIGIT, 2: bits added per clock. Must be at least 1.
- NDIG, WIDTH/DIGIT: derived (localparam) digit count, which is the RUN length in cycles.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operands present
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in
- out_valid  out  1  result present
- out_ready  in  1  consumer takes result
- sum  out  WIDTH  result
- cout  out  1  carry-out of bit WIDTH-1
- ovf  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Clocking and reset:
  - One clock.
  - rst asynchronous, active-high.
  - While rst=1 or after its release: state=IDLE, digit counter=0, carry reg=0, sum=0, cout=0, ovf=0, out_valid=0, in_ready=1.
- State IDLE:
  - in_ready=1, out_valid=0.
  - If in_valid=1 at a clk edge: latch a, b, cin (carry reg<=cin), clear digit counter, clear sum, go to RUN.
- State RUN:
  - in_ready=0, out_valid=0.
  - Each cycle, add digit k of a and b with carry reg.
  - Write the DIGIT result bits into sum[k*DIGIT +: DIGIT].
  - carry reg <= digit carry-out; k increments.
  - On the cycle with k=NDIG-1:
    - cout <= final carry.
    - ovf <= carry into bit WIDTH-1 XOR final carry.
    - Go to DONE.
- State DONE:
  - out_valid=1, in_ready=0.
  - sum, cout and ovf are held stable.
  - If out_ready=1 at an edge: go to IDLE.
  - sum, cout and ovf retain their values until the next accept.
- Latency:
  - out_valid rises exactly NDIG clocks after the accepting edge.
  - Throughput is one result per NDIG+2 cycles (no overlap of accept and drain).
- Boundary conditions:
  - in_valid while not IDLE is ignored; operands are not sampled.
  - out_ready while not DONE has no effect.
  - Digit counter wraps at NDIG-1 only. It never indexes past WIDTH.
  - DIGIT=WIDTH gives NDIG=1, i.e. a single RUN cycle.
  - rst asserted mid-RUN or in DONE aborts immediately: the partial result is discarded and all outputs take their reset values.
- Arithmetic is unsigned modulo 2^WIDTH. cout is the (WIDTH+1)-th bit.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), latched on accept.
  - When sub=1: b is bit-inverted before each digit, initial carry = ~cin, and result = a - b - cin.
  - cout reports borrow-out (inverted final carry). ovf is computed on the inverted-b addition.
- Undefined:
  - Port sub is absent; addition only.

Decomposition:
- Package serial_adder_pkg holds:
  - state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - a function computing NDIG;
  - a width-check constant used by an elaboration assertion (WIDTH % DIGIT == 0).
- Sub-module serial_adder_digit: combinational DIGIT-bit ripple adder.
  - Inputs: x[DIGIT], y[DIGIT], ci.
  - Outputs: s[DIGIT], co, c_msb (carry into top bit, for ovf).
  - Instantiated once in the top.

Test Plan (WIDTH=8, DIGIT=2):
- Reset: hold rst for 3 cycles mid-stream -> sum=0, cout=0, ovf=0, out_valid=0, in_ready=1; first accept after release works normally.
- 8'hFF + 8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0; out_valid high exactly 4 clocks after the accept edge.
- 8'h7F + 8'h01, cin=0 -> sum=8'h80, cout=0, ovf=1. Then 8'h3C + 8'h42, cin=1 -> sum=8'h7F, cout=0, ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> sum/cout stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle.
- Abort: assert rst 2 cycles into RUN (a=8'hAA, b=8'h55) -> outputs reset; next op 8'h10 + 8'h20 -> sum=8'h30.
- SERIAL_ADDER_SUB_EN: sub=1, 8'h05 - 8'h07, cin=0 -> sum=8'hFE, cout(borrow)=1; 8'h80 - 8'h01 -> sum=8'h7F, ovf=1.
